uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one UART Tx.
REQ-002 The block SHALL have parameter TIMEOUT, default 5000, giving the maximum clk cycles to wait for frame completion (one frame is 10 bits x 434 cycles = 4340 cycles at 50 MHz/115200).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port i_req, input, N_REQ bits: bit k set means requester k has a byte pending.
REQ-006 The block SHALL have port i_req_d, input, 8*N_REQ bits: byte k is i_req_d[8k+7:8k].
REQ-007 The block SHALL have port o_ack, output, N_REQ bits: one-cycle pulse when requester k's byte is taken.
REQ-008 The block SHALL have port o_done, output, N_REQ bits: one-cycle pulse when requester k's frame completes.
REQ-009 The block SHALL have port o_err, output, 1 bit: one-cycle pulse on timeout.
REQ-010 The block SHALL have port o_err_id, output, clog2(N_REQ) bits: the granted requester index, valid while o_err is high.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in every state other than IDLE.
REQ-012 The block SHALL have port o_tx_en, output, 1 bit: one-cycle start pulse to the UART Tx.
REQ-013 The block SHALL have port o_tx_d, output, 8 bits: byte to the UART Tx, held stable from the o_tx_en cycle until the frame ends.
REQ-014 The block SHALL have port i_tx_complete, input, 1 bit: one-cycle pulse from the UART Tx after the stop bit.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and BUSY, with all outputs registered.
REQ-016 In IDLE with i_req nonzero, the block SHALL select the first set bit at or above rr_ptr (wrapping modulo N_REQ) and register grant index g and the byte i_req_d[g].
REQ-017 On the transition from IDLE to LOAD, the block SHALL assert o_tx_en, o_ack[g] and o_busy in the same cycle, one clk after i_req is sampled.
REQ-018 LOAD SHALL last exactly one cycle and then go to BUSY, with the timeout counter cleared to 0.
REQ-019 In BUSY, the counter SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-020 When i_tx_complete is high in BUSY, the block SHALL go to IDLE, pulse o_done[g] the next cycle and set rr_ptr = (g+1) mod N_REQ.
REQ-021 When the counter reaches TIMEOUT-1 in BUSY without i_tx_complete, the block SHALL go to IDLE, pulse o_err with o_err_id = g, and set rr_ptr = (g+1) mod N_REQ.
REQ-022 If i_tx_complete and the timeout condition occur in the same cycle, completion SHALL win and o_err SHALL stay low.
REQ-023 i_tx_complete SHALL be ignored in IDLE and LOAD.
REQ-024 A requester SHALL hold i_req and its byte until o_ack; the byte is captured at grant, so later changes do not affect the frame.
REQ-025 A request withdrawn before grant SHALL be dropped, with no ack.
REQ-026 Back-to-back operation: the IDLE cycle after completion SHALL be able to grant again, giving a minimum of 2 clks from i_tx_complete to the next o_tx_en.
REQ-027 At most one o_ack bit and one o_done bit SHALL be high in any cycle.
REQ-028 The counter SHALL be clog2(TIMEOUT+1) bits wide, with no wrap-around.

Reset
REQ-029 While rst is high at a clk edge, the block SHALL force state to IDLE, rr_ptr to 0, counter to 0, g to 0, o_tx_d to 8'h00, and o_tx_en, o_ack, o_done, o_err, o_err_id and o_busy to 0.
REQ-030 Reset during LOAD or BUSY SHALL abandon the frame silently, with no o_done and no o_err; the downstream UART Tx is reset by its own reset.
REQ-031 The first grant after reset SHALL favour requester 0.

Structure
REQ-032 A shared package uart_pkg SHALL hold the state encoding (IDLE, LOAD, BUSY), CLK_HZ = 50_000_000, BAUD = 115200, BIT_CYCLES = 434 and the default TIMEOUT.
REQ-033 One combinational sub-module rr_arb SHALL compute the grant index and a valid flag from i_req and rr_ptr.
REQ-034 The top level SHALL hold the FSM, counter and output registers, within 120-400 lines of RTL total.

Verification
REQ-035 After reset, i_req = 4'b0001 with byte 8'h55 -> o_tx_en and o_ack = 4'b0001 one clk later, o_tx_d = 8'h55; after the model's complete pulse, o_done = 4'b0001.
REQ-036 i_req = 4'b1111 held continuously, bytes 8'hA0-A3 -> grant order 0, 1, 2, 3, 0, with each o_tx_en two clks after the previous i_tx_complete.
REQ-037 The UART model never pulses complete -> o_err high 5000 clks after o_tx_en with o_err_id = granted index, then the next request is granted normally.
REQ-038 i_tx_complete and timeout forced in the same cycle -> o_done pulses and o_err stays 0.
REQ-039 rst asserted mid-BUSY -> all outputs 0 next clk, no o_done or o_err, and the next grant goes to requester 0.
REQ-040 i_req[2] dropped before grant while i_req[1] is held -> only o_ack[1] pulses, and o_ack[2] never pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and UART timing constants for the Tx arbiter
package uart_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;
   localparam int CLK_HZ          = 50_000_000;
   localparam int BAUD            = 115200;
   localparam int BIT_CYCLES      = 434;
   localparam int TIMEOUT_DEFAULT = 5000;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: rotating-priority pick of the first request at or above ptr
module rr_arb #(
   parameter int N_REQ = 4,
   localparam int W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [W-1:0]     ptr,
   output logic [W-1:0]     grant,
   output logic             valid
);
   logic [W-1:0] idx;
   // scan from the farthest offset down so the nearest request at/after ptr wins
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = W'((int'(ptr) + i) % N_REQ);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART Tx among N_REQ byte requesters
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   localparam int W = N_REQ > 1 ? $clog2(N_REQ) : 1,
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [8*N_REQ-1:0] i_req_d,
   output logic [N_REQ-1:0]   o_ack,
   output logic [N_REQ-1:0]   o_done,
   output logic               o_err,
   output logic [W-1:0]       o_err_id,
   output logic               o_busy,
   output logic               o_tx_en,
   output logic [7:0]         o_tx_d,
   input  logic               i_tx_complete
);
   state_t state, state_n;
   logic [W-1:0] rr_ptr, g, arb_g;
   logic arb_v, grant_ev, done_ev, tmo_ev;
   logic [CW-1:0] cnt;
   logic [7:0] bytes [N_REQ];
   for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
      assign bytes[k] = i_req_d[8*k +: 8];
   end
   rr_arb #(.N_REQ(N_REQ)) u_arb (
      .req  (i_req),
      .ptr  (rr_ptr),
      .grant(arb_g),
      .valid(arb_v)
   );
   // timeout fires on the edge where the counter reaches TIMEOUT-1; completion has priority
   always_comb begin
      grant_ev = state == IDLE && arb_v;
      done_ev = state == BUSY && i_tx_complete;
      tmo_ev = state == BUSY && !i_tx_complete && cnt == CW'(TIMEOUT - 2);
      state_n = grant_ev ? LOAD
              : state == LOAD ? BUSY
              : state == BUSY && !done_ev && !tmo_ev ? BUSY : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         cnt <= '0;
         g <= '0;
         o_tx_d <= 8'h00;
         o_tx_en <= 1'b0;
         o_ack <= '0;
         o_done <= '0;
         o_err <= 1'b0;
         o_err_id <= '0;
         o_busy <= 1'b0;
      end else begin
         state <= state_n;
         o_busy <= state_n != IDLE;
         o_tx_en <= grant_ev;
         o_ack <= grant_ev ? N_REQ'(1) << arb_g : '0;
         o_done <= done_ev ? N_REQ'(1) << g : '0;
         o_err <= tmo_ev;
         o_err_id <= tmo_ev ? g : '0;
         cnt <= state != BUSY ? '0 : cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
         if (grant_ev) begin
            g <= arb_g;
            o_tx_d <= bytes[arb_g];
         end
         if (done_ev || tmo_ev) rr_ptr <= g == W'(N_REQ - 1) ? '0 : g + 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-timing reference model plus directed and random stimulus
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int TO = 5000;
   logic clk = 1'b0, rst = 1'b1, tx_complete = 1'b0;
   logic [N-1:0] req = '0;
   logic [8*N-1:0] req_d = '0;
   logic [N-1:0] o_ack, o_done;
   logic o_err, o_busy, o_tx_en;
   logic [1:0] o_err_id;
   logic [7:0] o_tx_d;
   int checks = 0, failures = 0, uart_mode = 0;
   int cyc = 0, t_en = 0, m_rr = 0, m_g = 0, idx;
   bit m_busy = 0, found;
   logic e_en = 0, e_err = 0, e_busy = 0;
   logic [N-1:0] e_ack = '0, e_done = '0;
   logic [1:0] e_eid = '0;
   logic [7:0] e_txd = '0;
   always #5 clk = ~clk;
   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .i_req(req), .i_req_d(req_d), .o_ack(o_ack), .o_done(o_done),
      .o_err(o_err), .o_err_id(o_err_id), .o_busy(o_busy), .o_tx_en(o_tx_en), .o_tx_d(o_tx_d),
      .i_tx_complete(tx_complete)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   // reference: a frame is described by its o_tx_en cycle t_en; everything else is time arithmetic
   always @(posedge clk) begin
      e_en = 0;
      e_ack = '0;
      e_done = '0;
      e_err = 0;
      if (rst) begin
         m_busy = 0;
         m_rr = 0;
         m_g = 0;
         e_txd = '0;
         e_eid = '0;
      end else if (!m_busy) begin
         found = 0;
         for (int i = 0; i < N; i++) begin
            idx = (m_rr + i) % N;
            if (!found && req[idx]) begin
               m_g = idx;
               found = 1;
            end
         end
         if (found) begin
            m_busy = 1;
            t_en = cyc + 1;
            e_en = 1;
            e_ack[m_g] = 1'b1;
            e_txd = req_d[8*m_g +: 8];
         end
      end else if (cyc > t_en && tx_complete) begin
         e_done[m_g] = 1'b1;
         m_busy = 0;
         m_rr = (m_g + 1) % N;
      end else if (cyc == t_en + TO - 1) begin
         e_err = 1;
         e_eid = 2'(m_g);
         m_busy = 0;
         m_rr = (m_g + 1) % N;
      end
      e_busy = m_busy;
      cyc++;
   end
   always @(negedge clk) begin
      chk("tx_en", o_tx_en, e_en);
      chk("ack", o_ack, e_ack);
      chk("done", o_done, e_done);
      chk("err", o_err, e_err);
      chk("busy", o_busy, e_busy);
      chk("tx_d", o_tx_d, e_txd);
      if (e_err) chk("err_id", o_err_id, e_eid);
   end
   // UART Tx stand-in: 0 = random frame length with stray idle pulses, 1 = silent, 2 = completes on the timeout cycle
   initial begin
      forever begin
         @(negedge clk);
         tx_complete = 1'b0;
         if (o_tx_en && uart_mode != 1) begin
            repeat (uart_mode == 2 ? TO - 1 : int'($urandom_range(1, 30))) @(negedge clk);
            tx_complete = 1'b1;
         end else if (uart_mode == 0 && !o_busy && $urandom_range(0, 15) == 0) tx_complete = 1'b1;
      end
   end
   task automatic wait_for(input int sel, input int lim, output int w);
      bit hit;
      hit = 0;
      w = 0;
      while (!hit && w < lim) begin
         @(negedge clk);
         w++;
         hit = sel == 0 ? |o_ack : sel == 1 ? |o_done : o_err;
      end
      if (!hit) chk($sformatf("wait_sel%0d", sel), 0, 1);
   endtask
   task automatic do_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      int w, n2;
      repeat (3) @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_en", o_tx_en, 0);
      chk("rst_ack", o_ack, 0);
      chk("rst_txd", o_tx_d, 0);
      rst = 1'b0;
      req = 4'b0001;
      req_d[7:0] = 8'h55;
      wait_for(0, 10, w);
      chk("single_lat", w, 1);
      chk("single_ack", o_ack, 4'b0001);
      chk("single_en", o_tx_en, 1);
      chk("single_txd", o_tx_d, 8'h55);
      req = '0;
      wait_for(1, 100, w);
      chk("single_done", o_done, 4'b0001);
      do_rst();
      req_d = 32'hA3A2A1A0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_for(0, 100, w);
         chk($sformatf("rr_lat%0d", k), w, 1);
         chk($sformatf("rr_ack%0d", k), o_ack, 1 << (k % 4));
         chk($sformatf("rr_txd%0d", k), o_tx_d, 8'hA0 + k % 4);
         wait_for(1, 100, w);
      end
      req = '0;
      uart_mode = 1;
      do_rst();
      req = 4'b0100;
      req_d[23:16] = 8'h3C;
      wait_for(0, 10, w);
      chk("to_ack", o_ack, 4'b0100);
      req = '0;
      wait_for(2, TO + 100, w);
      chk("to_lat", w, TO);
      chk("to_id", o_err_id, 2);
      chk("to_done", o_done, 0);
      uart_mode = 0;
      @(negedge clk);
      req = 4'b0001;
      req_d[7:0] = 8'h77;
      wait_for(0, 10, w);
      chk("after_to_ack", o_ack, 4'b0001);
      chk("after_to_txd", o_tx_d, 8'h77);
      req = '0;
      wait_for(1, 100, w);
      uart_mode = 2;
      @(negedge clk);
      req = 4'b1000;
      req_d[31:24] = 8'h99;
      wait_for(0, 10, w);
      chk("tie_ack", o_ack, 4'b1000);
      req = '0;
      wait_for(1, TO + 100, w);
      chk("tie_lat", w, TO);
      chk("tie_done", o_done, 4'b1000);
      chk("tie_err", o_err, 0);
      uart_mode = 0;
      @(negedge clk);
      req = 4'b0010;
      wait_for(0, 10, w);
      req = '0;
      wait_for(1, 100, w);
      uart_mode = 1;
      @(negedge clk);
      req = 4'b0100;
      wait_for(0, 10, w);
      chk("mid_ack", o_ack, 4'b0100);
      req = '0;
      repeat (3) @(negedge clk);
      chk("mid_busy", o_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_en", o_tx_en, 0);
      chk("mid_rst_ack", o_ack, 0);
      chk("mid_rst_done", o_done, 0);
      chk("mid_rst_err", o_err, 0);
      chk("mid_rst_txd", o_tx_d, 0);
      rst = 1'b0;
      uart_mode = 0;
      req = 4'b1111;
      wait_for(0, 10, w);
      chk("post_rst_ack", o_ack, 4'b0001);
      req = '0;
      wait_for(1, 100, w);
      @(negedge clk);
      req = 4'b0001;
      wait_for(0, 10, w);
      req = 4'b0110;
      @(negedge clk);
      req = 4'b0010;
      wait_for(0, 100, w);
      chk("wd_ack", o_ack, 4'b0010);
      req = '0;
      n2 = 0;
      repeat (60) begin
         @(negedge clk);
         if (o_ack[2]) n2++;
      end
      chk("wd_no_ack2", n2, 0);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = $urandom_range(0, 599) == 0;
         for (int k = 0; k < N; k++) begin
            if (req[k] && (o_ack[k] || $urandom_range(0, 63) == 0)) req[k] = 1'b0;
            else if (!req[k] && $urandom_range(0, 5) == 0) begin
               req[k] = 1'b1;
               req_d[8*k +: 8] = 8'($urandom);
            end
         end
      end
      rst = 1'b0;
      req = '0;
      repeat (40) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
